codec_reg_seq: RTL and testbench

Parametrised successor to the codec I2C init sequencer. Walks an external synchronous init ROM of LUT_SIZE register writes and drives the existing i2c_control write handshake. Retries NACKed transfers. After init, holds a saturating volume value controlled by debounced key pulses and UART set commands, and rewrites NUM_CH per-channel volume registers whenever that value changes. Sits between key_filter/uart_cmd and i2c_control, replacing the fixed-table/fixed-key logic.

---
 rtl/codec_seq_pkg.sv | 22 ++
 rtl/codec_vol_ctrl.sv | 59 +++++
 rtl/codec_reg_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_codec_reg_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_seq_pkg.sv
// codec_seq_pkg
//   Shared definitions for the codec register sequencer:
//   - seq_state_e : 3-bit sequencer state encoding
//   - ROM word layout: lut_q = {addr, data}, data in the low DATA_W bits,
//     addr directly above it starting at bit DATA_W.
package codec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_VREQ  = 3'd5,
    ST_VWAIT = 3'd6,
    ST_ERR   = 3'd7
  } seq_state_e;

  // Data field starts at bit 0; the address field starts right after it.
  localparam int ROM_DATA_LSB = 0;

endpackage

// File: rtl/codec_vol_ctrl.sv
// codec_vol_ctrl
//   Saturating volume register with set/up/down control and a dirty flag
//   that marks a pending codec rewrite.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   vol_up/vol_dn single-cycle step pulses (both together: no change)
//   set_valid     load set_val (clamped to VOL_MAX); wins over up/dn
//   set_val       absolute volume value
//   clear_dirty   acknowledge from the sequencer that a pass has started
//   vol           current volume
//   dirty         vol changed since the last clear_dirty
module codec_vol_ctrl #(
  parameter int VOL_W   = 4,
  parameter int VOL_MAX = 11,
  parameter int VOL_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vol_up,
  input  logic             vol_dn,
  input  logic             set_valid,
  input  logic [VOL_W-1:0] set_val,
  input  logic             clear_dirty,
  output logic [VOL_W-1:0] vol,
  output logic             dirty
);

  localparam logic [VOL_W-1:0] VMAX = VOL_W'(VOL_MAX);

  logic [VOL_W-1:0] vol_q, vol_d;
  logic             dirty_q, dirty_d;

  always_comb begin
    vol_d = vol_q;
    if (set_valid) begin
      vol_d = (set_val > VMAX) ? VMAX : set_val;
    end else if (vol_up && !vol_dn) begin
      if (vol_q < VMAX) vol_d = vol_q + VOL_W'(1);
    end else if (vol_dn && !vol_up) begin
      if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
    end
    // A change in the same cycle as clear_dirty must still schedule a pass.
    dirty_d = (vol_d != vol_q) || (dirty_q && !clear_dirty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_q   <= VOL_W'(VOL_RST);
      dirty_q <= 1'b0;
    end else begin
      vol_q   <= vol_d;
      dirty_q <= dirty_d;
    end
  end

  assign vol   = vol_q;
  assign dirty = dirty_q;

endmodule

// File: rtl/codec_reg_seq.sv
// codec_reg_seq
//   Walks an external synchronous init ROM and issues register writes through
//   the i2c_control write handshake, then rewrites NUM_CH volume registers
//   whenever the volume value changes.
// Ports:
//   Clk, Rst_n           clock, synchronous active-low reset
//   go                   start/restart init (accepted in IDLE, DONE, ERR)
//   vol_up, vol_dn       volume step pulses
//   vol_set_valid/_val   absolute volume load
//   lut_addr, lut_q      ROM index out, {addr,data} word back one cycle later
//   wrreg_req            one-cycle write request
//   reg_addr, reg_wrdata write target, held until rw_done
//   rw_done, ack         transfer complete; ack=1 means NACK
//   init_done, busy, err status
//   vol                  current volume
// Build option:
//   CODEC_SEQ_RETRY_EN   retry a NACKed write up to MAX_RETRY extra times;
//                        without it the first NACK goes to ERR.
//
// state | meaning
// IDLE  | waiting for go after reset
// FETCH | lut_addr presented, ROM word arriving
// REQ   | latch ROM word, launch write request
// WAIT  | init write in flight
// DONE  | init complete; start volume pass when dirty
// VREQ  | launch write of channel ch volume register
// VWAIT | volume write in flight
// ERR   | retries exhausted; waits for go
module codec_reg_seq
  import codec_seq_pkg::*;
#(
  parameter int LUT_SIZE       = 16,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int VOL_W          = 4,
  parameter int VOL_MAX        = 11,
  parameter int VOL_RST        = 0,
  parameter int NUM_CH         = 2,
  parameter int VOL_REG_BASE   = 8'h02,
  parameter int VOL_REG_STRIDE = 1,
  parameter int VOL_OR_MASK    = 8'h00,
  parameter int MAX_RETRY      = 3
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     go,
  input  logic                     vol_up,
  input  logic                     vol_dn,
  input  logic                     vol_set_valid,
  input  logic [VOL_W-1:0]         vol_set_val,
  output logic [7:0]               lut_addr,
  input  logic [ADDR_W+DATA_W-1:0] lut_q,
  output logic                     wrreg_req,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic [DATA_W-1:0]        reg_wrdata,
  input  logic                     rw_done,
  input  logic                     ack,
  output logic                     init_done,
  output logic                     busy,
  output logic                     err,
  output logic [VOL_W-1:0]         vol
);

  localparam int CH_W = (NUM_CH <= 1) ? 1 : $clog2(NUM_CH);

  seq_state_e        state_q, state_d;
  logic [7:0]        lut_addr_q, lut_addr_d;   // doubles as the init index
  logic              wrreg_req_q, wrreg_req_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wrdata_q, reg_wrdata_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              clear_dirty, dirty;
  logic              retry_clr, retry_inc, can_retry;
  logic [VOL_W-1:0]  vol_w;

  codec_vol_ctrl #(
    .VOL_W  (VOL_W),
    .VOL_MAX(VOL_MAX),
    .VOL_RST(VOL_RST)
  ) u_vol (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .vol_up     (vol_up),
    .vol_dn     (vol_dn),
    .set_valid  (vol_set_valid),
    .set_val    (vol_set_val),
    .clear_dirty(clear_dirty),
    .vol        (vol_w),
    .dirty      (dirty)
  );

`ifdef CODEC_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;

  always_comb begin
    retry_d = retry_q;
    if (retry_clr)      retry_d = '0;
    else if (retry_inc) retry_d = retry_q + RETRY_W'(1);
  end

  assign can_retry = (retry_q < RETRY_W'(MAX_RETRY));

  always_ff @(posedge Clk) begin
    if (!Rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`else
  // No counter: a NACK is final, so MAX_RETRY and the counter controls are dead.
  logic unused_retry;
  assign unused_retry = retry_clr ^ retry_inc ^ (MAX_RETRY != 0);
  assign can_retry    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    lut_addr_d   = lut_addr_q;
    wrreg_req_d  = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wrdata_d = reg_wrdata_q;
    init_done_d  = init_done_q;
    err_d        = err_q;
    ch_d         = ch_q;
    clear_dirty  = 1'b0;
    retry_clr    = 1'b0;
    retry_inc    = 1'b0;

    if (go && (state_q inside {ST_IDLE, ST_DONE, ST_ERR})) begin
      lut_addr_d  = 8'd0;
      init_done_d = 1'b0;
      err_d       = 1'b0;
      retry_clr   = 1'b1;
      state_d     = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_REQ;
        ST_REQ: begin
          reg_addr_d   = lut_q[DATA_W +: ADDR_W];
          reg_wrdata_d = lut_q[ROM_DATA_LSB +: DATA_W];
          wrreg_req_d  = 1'b1;
          state_d      = ST_WAIT;
        end
        ST_WAIT: begin
          if (rw_done) begin
            if (!ack) begin
              retry_clr = 1'b1;
              if (lut_addr_q == 8'(LUT_SIZE - 1)) begin
                init_done_d = 1'b1;
                state_d     = ST_DONE;
              end else begin
                lut_addr_d = lut_addr_q + 8'd1;
                state_d    = ST_FETCH;
              end
            end else if (can_retry) begin
              retry_inc = 1'b1;
              state_d   = ST_REQ;   // lut_addr unchanged, so lut_q still holds the word
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
        ST_DONE: begin
          if (dirty) begin
            clear_dirty = 1'b1;
            ch_d        = '0;
            state_d     = ST_VREQ;
          end
        end
        ST_VREQ: begin
          reg_addr_d   = ADDR_W'(VOL_REG_BASE + int'(ch_q) * VOL_REG_STRIDE);
          reg_wrdata_d = DATA_W'(vol_w) | DATA_W'(VOL_OR_MASK);
          wrreg_req_d  = 1'b1;
          state_d      = ST_VWAIT;
        end
        ST_VWAIT: begin
          if (rw_done) begin
            if (!ack) begin
              retry_clr = 1'b1;
              if (ch_q == CH_W'(NUM_CH - 1)) begin
                state_d = ST_DONE;
              end else begin
                ch_d    = ch_q + CH_W'(1);
                state_d = ST_VREQ;
              end
            end else if (can_retry) begin
              retry_inc = 1'b1;
              state_d   = ST_VREQ;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
        default: ;  // IDLE, ERR: only go leaves
      endcase
    end

    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      lut_addr_q   <= 8'd0;
      wrreg_req_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_wrdata_q <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      ch_q         <= '0;
    end else begin
      state_q      <= state_d;
      lut_addr_q   <= lut_addr_d;
      wrreg_req_q  <= wrreg_req_d;
      reg_addr_q   <= reg_addr_d;
      reg_wrdata_q <= reg_wrdata_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      ch_q         <= ch_d;
    end
  end

  assign lut_addr   = lut_addr_q;
  assign wrreg_req  = wrreg_req_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wrdata = reg_wrdata_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign vol        = vol_w;

endmodule

// File: tb/tb_codec_reg_seq.sv
// tb_codec_reg_seq
//   Directed bench for codec_reg_seq with LUT_SIZE=4: synchronous ROM model,
//   an i2c_control responder driven by an ack plan, and checks on the logged
//   write stream and status outputs. Expectations follow CODEC_SEQ_RETRY_EN.
module tb_codec_reg_seq;

  logic        clk = 1'b0;
  logic        rst_n, go, vol_up, vol_dn, vol_set_valid;
  logic [3:0]  vol_set_val;
  logic [7:0]  lut_addr;
  logic [15:0] lut_q;
  logic        wrreg_req;
  logic [7:0]  reg_addr, reg_wrdata;
  logic        rw_done, ack;
  logic        init_done, busy, err;
  logic [3:0]  vol;

  logic [15:0] rom [4];
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];
  bit          ack_plan[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc_cnt = 0;
  int          last_done_edge = 0;

  always #5 clk = ~clk;

  codec_reg_seq #(.LUT_SIZE(4)) dut (
    .Clk(clk), .Rst_n(rst_n), .go(go), .vol_up(vol_up), .vol_dn(vol_dn),
    .vol_set_valid(vol_set_valid), .vol_set_val(vol_set_val),
    .lut_addr(lut_addr), .lut_q(lut_q), .wrreg_req(wrreg_req),
    .reg_addr(reg_addr), .reg_wrdata(reg_wrdata), .rw_done(rw_done), .ack(ack),
    .init_done(init_done), .busy(busy), .err(err), .vol(vol)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) lut_q <= rom[lut_addr[1:0]];

  // i2c_control stand-in: completes each request three edges later.
  initial begin
    rw_done = 1'b0;
    ack     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wrreg_req) begin
        log_q.push_back({reg_addr, reg_wrdata});
        repeat (2) begin @(posedge clk); #1; end
        rw_done = 1'b1;
        ack = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
        last_done_edge = cyc_cnt + 1;
        @(posedge clk); #1;
        rw_done = 1'b0;
        ack     = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_go();
    go = 1'b1; step(1); go = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(init_done || err) && n < budget) begin step(1); n++; end
    check("end_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s_count", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic set_vol(input logic [3:0] v, input logic up);
    vol_set_valid = 1'b1; vol_set_val = v; vol_up = up;
    step(1);
    vol_set_valid = 1'b0; vol_set_val = 4'd0; vol_up = 1'b0;
  endtask

  initial begin
    rom[0] = 16'h1081; rom[1] = 16'h2142; rom[2] = 16'h3203; rom[3] = 16'h43C4;
    rst_n = 1'b0; go = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
    vol_set_valid = 1'b0; vol_set_val = 4'd0;
    step(3);
    check("rst_wrreg", wrreg_req, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_vol", vol, 0);
    check("rst_lut_addr", lut_addr, 0);
    check("rst_reg_addr", reg_addr, 0);
    rst_n = 1'b1;
    step(2);

    // Clean init, all ACKed
    log_q.delete();
    exp_q = '{rom[0], rom[1], rom[2], rom[3]};
    pulse_go();
    check("go_busy", busy, 1);
    wait_end(200);
    check("init_done_edge", cyc_cnt, last_done_edge);
    check("init_done", init_done, 1);
    check("init_busy", busy, 0);
    check("init_err", err, 0);
    check_log("init");
    step(10);
    check("init_no_extra", log_q.size(), 4);

    // Entry 2 NACKed twice
    log_q.delete();
`ifdef CODEC_SEQ_RETRY_EN
    ack_plan = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = '{rom[0], rom[1], rom[2], rom[2], rom[2], rom[3]};
`else
    ack_plan = '{1'b0, 1'b0, 1'b1};
    exp_q = '{rom[0], rom[1], rom[2]};
`endif
    pulse_go();
    wait_end(300);
    step(2);
`ifdef CODEC_SEQ_RETRY_EN
    check("nack2_init_done", init_done, 1);
    check("nack2_err", err, 0);
`else
    check("nack2_init_done", init_done, 0);
    check("nack2_err", err, 1);
`endif
    check_log("nack2");

    // Entry 1 NACKed four times
    log_q.delete();
    ack_plan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef CODEC_SEQ_RETRY_EN
    exp_q = '{rom[0], rom[1], rom[1], rom[1], rom[1]};
`else
    exp_q = '{rom[0], rom[1]};
`endif
    pulse_go();
    wait_end(300);
    check("nack4_err", err, 1);
    check("nack4_busy", busy, 0);
    check("nack4_init_done", init_done, 0);
    step(10);
    check_log("nack4");
    ack_plan.delete();

    // Restart from ERR
    log_q.delete();
    exp_q = '{rom[0], rom[1], rom[2], rom[3]};
    pulse_go();
    check("restart_err_clr", err, 0);
    wait_end(200);
    check("restart_init_done", init_done, 1);
    check_log("restart");

    // Volume passes
    log_q.delete();
    set_vol(4'd5, 1'b0);
    check("vol_set5", vol, 5);
    step(30);
    exp_q = '{16'h0205, 16'h0305};
    check_log("pass5");

    log_q.delete();
    vol_up = 1'b1; step(1); vol_up = 1'b0;
    check("vol_up6", vol, 6);
    step(30);
    exp_q = '{16'h0206, 16'h0306};
    check_log("pass6");

    set_vol(4'd11, 1'b0);
    step(30);
    log_q.delete();
    vol_up = 1'b1; step(1); vol_up = 1'b0;
    check("vol_up_sat", vol, 11);
    step(30);
    check("up_sat_no_write", log_q.size(), 0);

    set_vol(4'd0, 1'b0);
    step(30);
    log_q.delete();
    vol_dn = 1'b1; step(1); vol_dn = 1'b0;
    check("vol_dn_sat", vol, 0);
    vol_up = 1'b1; vol_dn = 1'b1; step(1); vol_up = 1'b0; vol_dn = 1'b0;
    check("vol_updn", vol, 0);
    step(30);
    check("dn_sat_no_write", log_q.size(), 0);

    // Set 15 with simultaneous up: set wins and clamps
    log_q.delete();
    set_vol(4'd15, 1'b1);
    check("vol_clamp", vol, 11);
    step(30);
    exp_q = '{16'h020B, 16'h030B};
    check_log("pass11");

    // Reset in WAIT of entry 2
    log_q.delete();
    begin
      int n = 0;
      pulse_go();
      while (log_q.size() < 3 && n < 100) begin step(1); n++; end
      check("reach_entry2", 32'(n < 100), 32'd1);
    end
    check("mid_lut_addr", lut_addr, 2);
    rst_n = 1'b0;
    step(1);
    check("mrst_wrreg", wrreg_req, 0);
    check("mrst_busy", busy, 0);
    check("mrst_init_done", init_done, 0);
    check("mrst_err", err, 0);
    check("mrst_vol", vol, 0);
    check("mrst_lut_addr", lut_addr, 0);
    check("mrst_reg_addr", reg_addr, 0);
    check("mrst_reg_wrdata", reg_wrdata, 0);
    step(8);
    rst_n = 1'b1;
    step(2);
    log_q.delete();
    exp_q = '{rom[0], rom[1], rom[2], rom[3]};
    pulse_go();
    check("post_rst_lut_addr", lut_addr, 0);
    wait_end(200);
    check("post_rst_init_done", init_done, 1);
    check_log("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
